// File: rtl/extend_pkg.sv
// Shared types and constants for the pipelined immediate extender.
//   imm_src_t   : extension mode carried on ImmSrc
//   ext_state_t : prefix-join FSM state
//   LOW_FIELD_W : width of the low immediate field joined under a prefix
//   Z7_W        : width of the short zero-extended field
package extend_pkg;

  typedef enum logic [1:0] {
    IMM_Z11   = 2'b00,
    IMM_ZFULL = 2'b01,
    IMM_S11   = 2'b10,
    IMM_Z7    = 2'b11
  } imm_src_t;

  typedef enum logic {
    IDLE     = 1'b0,
    PREFIXED = 1'b1
  } ext_state_t;

  localparam int unsigned LOW_FIELD_W = 11;
  localparam int unsigned Z7_W        = 7;

endpackage

// File: rtl/extend_comb_v3.sv
// Combinational mode/prefix mux for the immediate extender.
// Ports:
//   a_i          raw immediate field
//   imm_src_i    extension mode
//   prefixed_i   a prefix is latched and waiting to be joined
//   prefix_i     latched upper immediate bits (N-11 wide)
//   ext_imm_o    extended immediate
//   prefix_err_o the latched prefix is dropped because this mode cannot take it
module extend_comb_v3
  import extend_pkg::*;
#(
  parameter int unsigned N  = 24,
  parameter int unsigned IW = 19
) (
  input  logic [IW-1:0]            a_i,
  input  imm_src_t                 imm_src_i,
  input  logic                     prefixed_i,
  input  logic [N-LOW_FIELD_W-1:0] prefix_i,
  output logic [N-1:0]             ext_imm_o,
  output logic                     prefix_err_o
);

  always_comb begin
    ext_imm_o    = '0;
    prefix_err_o = 1'b0;
    if (prefixed_i && (imm_src_i == IMM_Z11 || imm_src_i == IMM_S11)) begin
      // Joined immediate: prefix supplies the upper bits, no sign extension.
      ext_imm_o = {prefix_i, a_i[LOW_FIELD_W-1:0]};
    end else begin
      prefix_err_o = prefixed_i;
      unique case (imm_src_i)
        IMM_Z11:   ext_imm_o[LOW_FIELD_W-1:0] = a_i[LOW_FIELD_W-1:0];
        IMM_ZFULL: ext_imm_o[IW-1:0] = a_i;
        IMM_S11: begin
          ext_imm_o = {N{a_i[LOW_FIELD_W-1]}};
          ext_imm_o[LOW_FIELD_W-1:0] = a_i[LOW_FIELD_W-1:0];
        end
        IMM_Z7:    ext_imm_o[Z7_W-1:0] = a_i[Z7_W-1:0];
        default:   ext_imm_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/extend_pipe_unit.sv
// Pipelined immediate extender with prefix-based long immediates.
// A prefix beat latches upper immediate bits; the next non-prefix beat in mode 00/10
// is joined with it into one N-bit immediate. Output is registered behind a
// valid/ready handshake.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               clears FSM, prefix and output register; blocks input
//   in_valid/in_ready   input handshake
//   A, ImmSrc           raw immediate field and extension mode
//   in_prefix           beat carries upper immediate bits only
//   in_tag/out_tag      sideband registered alongside the immediate
//   out_valid/out_ready output handshake
//   ExtImm              extended immediate
//   out_prefix_err      latched prefix was dropped for this beat
//   prefix_busy         a prefix is latched (FSM in PREFIXED)
module extend_pipe_unit
  import extend_pkg::*;
#(
  parameter int unsigned N  = 24,
  parameter int unsigned IW = 19,
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] A,
  input  logic [1:0]    ImmSrc,
  input  logic          in_prefix,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  ExtImm,
  output logic [TW-1:0] out_tag,
  output logic          out_prefix_err,
  output logic          prefix_busy
);

  localparam int unsigned PW = N - LOW_FIELD_W;

  ext_state_t    state_q, state_d;
  logic [PW-1:0] prefix_q, prefix_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  ext_imm_q, ext_imm_d;
  logic [TW-1:0] out_tag_q, out_tag_d;
  logic          prefix_err_q, prefix_err_d;

  logic          accept;
  logic [N-1:0]  comb_imm;
  logic          comb_err;

  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  extend_comb_v3 #(
    .N  (N),
    .IW (IW)
  ) u_comb (
    .a_i          (A),
    .imm_src_i    (imm_src_t'(ImmSrc)),
    .prefixed_i   (state_q == PREFIXED),
    .prefix_i     (prefix_q),
    .ext_imm_o    (comb_imm),
    .prefix_err_o (comb_err)
  );

  always_comb begin
    state_d      = state_q;
    prefix_d     = prefix_q;
    out_valid_d  = out_valid_q;
    ext_imm_d    = ext_imm_q;
    out_tag_d    = out_tag_q;
    prefix_err_d = prefix_err_q;
    if (flush) begin
      state_d      = IDLE;
      prefix_d     = '0;
      out_valid_d  = 1'b0;
      ext_imm_d    = '0;
      out_tag_d    = '0;
      prefix_err_d = 1'b0;
    end else if (accept) begin
      if (in_prefix) begin
        // A prefix produces no output; any beat held in the register was consumed.
        prefix_d    = A[PW-1:0];
        state_d     = PREFIXED;
        out_valid_d = 1'b0;
      end else begin
        ext_imm_d    = comb_imm;
        out_tag_d    = in_tag;
        prefix_err_d = comb_err;
        out_valid_d  = 1'b1;
        state_d      = IDLE;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prefix_q     <= '0;
      out_valid_q  <= 1'b0;
      ext_imm_q    <= '0;
      out_tag_q    <= '0;
      prefix_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prefix_q     <= prefix_d;
      out_valid_q  <= out_valid_d;
      ext_imm_q    <= ext_imm_d;
      out_tag_q    <= out_tag_d;
      prefix_err_q <= prefix_err_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign ExtImm         = ext_imm_q;
  assign out_tag        = out_tag_q;
  assign out_prefix_err = prefix_err_q;
  assign prefix_busy    = (state_q == PREFIXED);

endmodule

// File: tb/tb_extend_pipe_unit.sv
module tb_extend_pipe_unit;

  localparam int unsigned N  = 24;
  localparam int unsigned IW = 19;
  localparam int unsigned TW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] a;
  logic [1:0]    imm_src;
  logic          in_prefix;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  ext_imm;
  logic [TW-1:0] out_tag;
  logic          out_prefix_err;
  logic          prefix_busy;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  extend_pipe_unit #(
    .N  (N),
    .IW (IW),
    .TW (TW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .A              (a),
    .ImmSrc         (imm_src),
    .in_prefix      (in_prefix),
    .in_tag         (in_tag),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .ExtImm         (ext_imm),
    .out_tag        (out_tag),
    .out_prefix_err (out_prefix_err),
    .prefix_busy    (prefix_busy)
  );

  // Reference extension computed with plain arithmetic from the mode rules.
  function automatic logic [N-1:0] ref_ext(input bit prefixed, input longint unsigned pre,
                                           input int unsigned mode, input longint unsigned av,
                                           output bit err);
    longint unsigned lo;
    longint unsigned v;
    lo  = av % 2048;
    err = 1'b0;
    v   = 0;
    if (prefixed && (mode == 0 || mode == 2)) begin
      v = pre * 2048 + lo;
    end else begin
      err = prefixed;
      case (mode)
        0: v = lo;
        1: v = av;
        2: v = (lo >= 1024) ? lo + (64'd1 << N) - 2048 : lo;
        default: v = av % 128;
      endcase
    end
    return v[N-1:0];
  endfunction

  // Transaction-level model of the unit's visible state.
  bit               m_valid    = 0;
  bit               m_prefixed = 0;
  longint unsigned  m_prefix   = 0;
  logic [N-1:0]     m_imm      = '0;
  logic [TW-1:0]    m_tag      = '0;
  bit               m_err      = 0;
  bit               m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0; m_prefixed <= 0; m_prefix <= 0; m_imm <= '0; m_tag <= '0; m_err <= 0;
    end else if (flush) begin
      m_valid <= 0; m_prefixed <= 0; m_prefix <= 0; m_imm <= '0; m_tag <= '0; m_err <= 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      if (in_prefix) begin
        m_prefix   <= a % (64'd1 << (N - 11));
        m_prefixed <= 1;
        m_valid    <= 0;
      end else begin
        m_imm      <= ref_ext(m_prefixed, m_prefix, imm_src, a, m_e);
        m_err      <= m_e;
        m_tag      <= in_tag;
        m_valid    <= 1;
        m_prefixed <= 0;
      end
    end else if (out_ready) begin
      m_valid <= 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit p, input logic [1:0] m, input logic [IW-1:0] av,
                       input logic [TW-1:0] t);
    in_valid = v; in_prefix = p; imm_src = m; a = av; in_tag = t;
  endtask

  task automatic test_reset();
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || ext_imm !== '0 || out_tag !== '0 || out_prefix_err !== 1'b0
        || prefix_busy !== 1'b0) begin
      $display("FAIL reset_state: valid=%b imm=%h tag=%h err=%b busy=%b required all 0",
               out_valid, ext_imm, out_tag, out_prefix_err, prefix_busy);
      n_fails++;
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_modes();
    logic [1:0]    modes [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic [IW-1:0] avals [4] = '{19'h12ABC, 19'h00456, 19'h7FFFF, 19'h000FF};
    logic [N-1:0]  exps  [4] = '{24'h0002BC, 24'hFFFC56, 24'h07FFFF, 24'h00007F};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, modes[i], avals[i], TW'(i + 8'h10));
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        $display("FAIL mode%0d_in_ready: got %b required 1", i, in_ready);
        n_fails++;
      end
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || ext_imm !== exps[i] || out_tag !== TW'(i + 8'h10)
          || out_prefix_err !== 1'b0) begin
        $display("FAIL mode%0d_value: valid=%b imm=%h tag=%h err=%b required 1 %h %h 0",
                 i, out_valid, ext_imm, out_tag, out_prefix_err, exps[i], TW'(i + 8'h10));
        n_fails++;
      end
    end
  endtask

  task automatic test_prefix_join();
    drive(1, 1, 2'b00, 19'h01ABC, 8'h21);
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || prefix_busy !== 1'b1) begin
      $display("FAIL join_prefix_beat: valid=%b busy=%b required 0 1", out_valid, prefix_busy);
      n_fails++;
    end
    drive(1, 0, 2'b00, 19'h00123, 8'h22);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || ext_imm !== 24'hD5E123 || out_prefix_err !== 1'b0
        || prefix_busy !== 1'b0 || out_tag !== 8'h22) begin
      $display("FAIL join_value: valid=%b imm=%h err=%b busy=%b tag=%h required 1 d5e123 0 0 22",
               out_valid, ext_imm, out_prefix_err, prefix_busy, out_tag);
      n_fails++;
    end
  endtask

  task automatic test_prefix_drop();
    drive(1, 1, 2'b00, 19'h01ABC, 8'h31);
    tick();
    drive(1, 0, 2'b11, 19'h00005, 8'h32);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || ext_imm !== 24'h000005 || out_prefix_err !== 1'b1
        || prefix_busy !== 1'b0) begin
      $display("FAIL drop_value: valid=%b imm=%h err=%b busy=%b required 1 000005 1 0",
               out_valid, ext_imm, out_prefix_err, prefix_busy);
      n_fails++;
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL drop_consumed: valid=%b required 0", out_valid);
      n_fails++;
    end
  endtask

  task automatic test_back_to_back();
    logic [IW-1:0] av [9];
    logic [1:0]    md [9];
    logic [N-1:0]  ex [9];
    bit            e;
    for (int i = 0; i < 9; i++) begin
      av[i] = IW'($urandom);
      md[i] = 2'($urandom_range(0, 3));
      ex[i] = ref_ext(0, 0, md[i], av[i], e);
    end
    out_ready = 1'b0;
    drive(1, 0, md[0], av[0], 8'h40);
    tick();
    drive(1, 0, md[1], av[1], 8'h41);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || ext_imm !== ex[0] || out_tag !== 8'h40) begin
        $display("FAIL stall_hold%0d: rdy=%b valid=%b imm=%h tag=%h required 0 1 %h 40",
                 c, in_ready, out_valid, ext_imm, out_tag, ex[0]);
        n_fails++;
      end
      tick();
    end
    out_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      drive(1, 0, md[i], av[i], TW'(8'h40 + i));
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        $display("FAIL stream%0d_in_ready: got %b required 1", i, in_ready);
        n_fails++;
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || ext_imm !== ex[i] || out_tag !== TW'(8'h40 + i)) begin
        $display("FAIL stream%0d_value: valid=%b imm=%h tag=%h required 1 %h %h",
                 i, out_valid, ext_imm, out_tag, ex[i], TW'(8'h40 + i));
        n_fails++;
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    drive(1, 1, 2'b00, 19'h01ABC, 8'h51);
    tick();
    flush = 1'b1;
    drive(1, 0, 2'b00, 19'h00777, 8'h52);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      $display("FAIL flush_in_ready: got %b required 0", in_ready);
      n_fails++;
    end
    tick();
    flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || prefix_busy !== 1'b0) begin
      $display("FAIL flush_cleared: valid=%b busy=%b required 0 0", out_valid, prefix_busy);
      n_fails++;
    end
    drive(1, 0, 2'b00, 19'h00123, 8'h53);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || ext_imm !== 24'h000123 || out_prefix_err !== 1'b0) begin
      $display("FAIL flush_after: valid=%b imm=%h err=%b required 1 000123 0",
               out_valid, ext_imm, out_prefix_err);
      n_fails++;
    end
    // Flush with a beat held under backpressure.
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL flush_drops_held: valid=%b required 0", out_valid);
      n_fails++;
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 2'b00, 19'h01ABC, 8'h61);
    tick();
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (prefix_busy !== 1'b0 || out_valid !== 1'b0) begin
      $display("FAIL rst_prefixed: busy=%b valid=%b required 0 0", prefix_busy, out_valid);
      n_fails++;
    end
    rst_n = 1'b1;
    out_ready = 1'b0;
    tick();
    drive(1, 0, 2'b01, 19'h5A5A5, 8'h62);
    tick();
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || ext_imm !== '0 || out_tag !== '0 || out_prefix_err !== 1'b0) begin
      $display("FAIL rst_valid: valid=%b imm=%h tag=%h err=%b required all 0",
               out_valid, ext_imm, out_tag, out_prefix_err);
      n_fails++;
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    drive(1, 0, 2'b00, 19'h00123, 8'h63);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || ext_imm !== 24'h000123 || prefix_busy !== 1'b0) begin
      $display("FAIL rst_after: valid=%b imm=%h busy=%b required 1 000123 0",
               out_valid, ext_imm, prefix_busy);
      n_fails++;
    end
  endtask

  task automatic test_random();
    bit exp_rdy;
    for (int c = 0; c < 400; c++) begin
      flush     = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
            IW'($urandom), TW'($urandom));
      #1;
      exp_rdy = !flush && (!m_valid || out_ready);
      n_checks++;
      if (in_ready !== exp_rdy) begin
        $display("FAIL rand%0d_in_ready: got %b required %b", c, in_ready, exp_rdy);
        n_fails++;
      end
      tick();
      n_checks++;
      if (out_valid !== m_valid || prefix_busy !== m_prefixed) begin
        $display("FAIL rand%0d_ctrl: valid=%b busy=%b required %b %b",
                 c, out_valid, prefix_busy, m_valid, m_prefixed);
        n_fails++;
      end
      if (m_valid) begin
        n_checks++;
        if (ext_imm !== m_imm || out_tag !== m_tag || out_prefix_err !== m_err) begin
          $display("FAIL rand%0d_data: imm=%h tag=%h err=%b required %h %h %b",
                   c, ext_imm, out_tag, out_prefix_err, m_imm, m_tag, m_err);
          n_fails++;
        end
      end
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(0, 0, 2'b00, '0, '0);
    test_reset();
    test_modes();
    test_prefix_join();
    test_prefix_drop();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
